mc_mem_responder: RTL and testbench
===================================

// Module: mc_mem_responder
// PURPOSE
// - Memory-side responder for the multicycle datapath's memory requests (MemRead/MemWrite).
// - Single-port word RAM with a configurable wait-state count.
// - Four-phase request/ready handshake, so the control FSM can stall until MemReady.
// - Sits between the datapath address/write-data path and the instruction/data capture registers.
// PARAMETERS
// - Nbits       32  data word width
// - ADDR_BITS   8   word-address width; depth = 2**ADDR_BITS words
// - WAIT_CYCLES 2   cycles spent in BUSY before the response; 0 is legal
// PORTS
// - clk        in   1          rising-edge clock
// - rst        in   1          synchronous, active-high reset
// - MemRead    in   1          read request level
// - MemWrite   in   1          write request level
// - Addr       in   ADDR_BITS+2  byte address; word index = Addr[ADDR_BITS+1:2]
// - WriteData  in   Nbits      data to store on write
// - ReadData   out  Nbits      read result, registered
// - MemReady   out  1          response valid, registered
// - MemErr     out  1          misaligned-access flag, registered (see CONFIGURATION)
// BEHAVIOUR
// - Reset state (sync on rst==1):
//   - state = IDLE; ReadData = 0, MemReady = 0, MemErr = 0; wait counter = 0.
//   - RAM contents are not reset.
//   - A request in flight at reset is discarded, including a pending write.
// - FSM state IDLE:
//   - Accept when MemRead|MemWrite == 1.
//   - Latch op, word index and WriteData; load counter with WAIT_CYCLES.
//   - Next state is BUSY, or RESP directly if WAIT_CYCLES == 0.
// - FSM state BUSY:
//   - Counter decrements each cycle; go to RESP on the cycle the counter reaches 1.
//   - Input changes are ignored; the latched request is used.
// - FSM state RESP (one-cycle action):
//   - Write: RAM[idx] <= latched WriteData.
//   - Read: ReadData <= RAM[idx].
//   - Set MemReady = 1; go to HOLD.
// - FSM state HOLD:
//   - MemReady stays 1 and ReadData is held.
//   - When MemRead|MemWrite == 0: MemReady <= 0 and state <= IDLE.
//   - This is a four-phase handshake; the requester must drop its request after seeing MemReady.
// - Latency from the accept edge to MemReady high: WAIT_CYCLES+1 clocks.
// - MemRead and MemWrite both high at accept: treated as a write; ReadData keeps its prior value.
// - Writes leave ReadData unchanged.
// - Back-to-back accesses: the earliest new accept is the cycle after the return to IDLE.
// - Address wrap: the word index uses only Addr[ADDR_BITS+1:2]; upper bits do not exist.
// - Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.
// CONFIGURATION
// - Macro MC_MEM_ALIGN_CHECK_EN, defined:
//   - At accept, Addr[1:0] != 0 sets an error flag.
//   - RESP then performs no RAM write and sets ReadData = 0, MemErr = 1.
//   - MemErr clears together with MemReady.
//   - Latency is unchanged.
// - Macro MC_MEM_ALIGN_CHECK_EN, undefined:
//   - Addr[1:0] is ignored and MemErr is tied to 0.
// STRUCTURE
// - Package mc_mem_pkg:
//   - State encoding localparams: IDLE=2'd0, BUSY=2'd1, RESP=2'd2, HOLD=2'd3.
//   - Function clog2_min1 for the counter width.
// - One sub-module, mc_mem_wait_counter:
//   - Inputs: load, value.
//   - Behaviour: decrement while nonzero.
//   - Output: a last-cycle pulse.
// - FSM, latches and RAM stay in the top module.
// TESTING
// - Reset then idle: rst high for 2 cycles -> ReadData==0, MemReady==0, MemErr==0.
// - Write then read, WAIT_CYCLES=2:
//   - Stimulus: write 32'hDEADBEEF @Addr 0x10; read @0x10.
//   - Response: MemReady high 3 clocks after each accept; ReadData==32'hDEADBEEF.
// - Handshake hold: keep MemRead high 5 cycles after MemReady -> MemReady stays 1 until drop.
//   MemReady falls on the next edge; no second access starts.
// - WAIT_CYCLES=0 and simultaneous MemRead+MemWrite:
//   - Stimulus: both high with WriteData 32'h1234 @0x04.
//   - Response: MemReady 1 clock after accept; a later read of 0x04 returns 32'h1234.
// - Reset mid-access: rst in BUSY of a write of 32'hA5A5 to 0x08 -> IDLE, outputs 0.
//   A later read of 0x08 returns the old value.
// - With MC_MEM_ALIGN_CHECK_EN: write @0x11 -> MemErr=1 with MemReady, ReadData=0.
//   The word at 0x10 is unchanged.

Source files
------------

// File: rtl/mc_mem_pkg.sv
// Shared types and helpers for the multicycle memory responder.
package mc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } mc_mem_state_e;

  // Ceil-log2 that never returns zero, so a zero wait count still gets a 1-bit counter.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 32'($clog2(n));
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/mc_mem_wait_counter.sv
// Wait-state down-counter: loads a count, decrements to zero, flags the final BUSY cycle.
module mc_mem_wait_counter #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          last_c
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign last_c = (cnt_q == CW'(1)) && !load;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_mem_responder.sv
// Single-port word RAM responder with wait states and a four-phase request/ready handshake.
// Optional misaligned-access detection is enabled by defining MC_MEM_ALIGN_CHECK_EN.
module mc_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int unsigned Nbits       = 32,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [ADDR_BITS+1:0] Addr,
  input  logic [Nbits-1:0]     WriteData,
  output logic [Nbits-1:0]     ReadData,
  output logic                 MemReady,
  output logic                 MemErr
);

  localparam int unsigned CW    = clog2_min1(WAIT_CYCLES + 1);
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  mc_mem_state_e          state_q, state_d;
  logic                   wr_q, wr_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [Nbits-1:0]       wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [Nbits-1:0]       read_data_q, read_data_d;
  logic                   ready_q, ready_d;
  logic                   mem_err_q, mem_err_d;
  logic [Nbits-1:0]       mem_q [DEPTH];

  logic req_c;
  logic load_c;
  logic last_c;
  logic mem_we_c;
  logic align_err_c;

  assign req_c = MemRead | MemWrite;

`ifdef MC_MEM_ALIGN_CHECK_EN
  assign align_err_c = (Addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Addr[1:0];
  assign align_err_c     = 1'b0;
`endif

  mc_mem_wait_counter #(
    .CW(CW)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .value  (CW'(WAIT_CYCLES)),
    .last_c (last_c)
  );

  // Next-state and output logic; the request is latched at accept and held until RESP.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    read_data_d = read_data_q;
    ready_d     = ready_q;
    mem_err_d   = mem_err_q;
    load_c      = 1'b0;
    mem_we_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          wr_d    = MemWrite;
          idx_d   = Addr[ADDR_BITS+1:2];
          wdata_d = WriteData;
          err_d   = align_err_c;
          load_c  = 1'b1;
          state_d = (WAIT_CYCLES == 0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (last_c) begin
          state_d = RESP;
        end
      end
      RESP: begin
        ready_d   = 1'b1;
        mem_err_d = err_q;
        if (err_q) begin
          read_data_d = '0;
        end else if (wr_q) begin
          mem_we_c = 1'b1;
        end else begin
          read_data_d = mem_q[idx_q];
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (!req_c) begin
          ready_d   = 1'b0;
          mem_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // RAM is never reset, but a write landing on a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ReadData = read_data_q;
  assign MemReady = ready_q;
  assign MemErr   = mem_err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed, table-driven bench for mc_mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_mc_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        rd2, wr2, rdy2, err2;
  logic [9:0]  addr2;
  logic [31:0] wd2, rdata2;

  logic        rd0, wr0, rdy0, err0;
  logic [9:0]  addr0;
  logic [31:0] wd0, rdata0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_mem_responder #(.Nbits(32), .ADDR_BITS(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .MemRead(rd2), .MemWrite(wr2), .Addr(addr2),
    .WriteData(wd2), .ReadData(rdata2), .MemReady(rdy2), .MemErr(err2)
  );

  mc_mem_responder #(.Nbits(32), .ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .Addr(addr0),
    .WriteData(wd0), .ReadData(rdata0), .MemReady(rdy0), .MemErr(err0)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input bit sel0, input logic rd, input logic wr,
                       input logic [9:0] a, input logic [31:0] wd);
    if (sel0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = a; wd2 = wd;
    end
  endtask

  function automatic logic get_rdy(input bit sel0);
    return sel0 ? rdy0 : rdy2;
  endfunction

  function automatic logic get_err(input bit sel0);
    return sel0 ? err0 : err2;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel0);
    return sel0 ? rdata0 : rdata2;
  endfunction

  // Request, scramble inputs while busy, wait for ready, check, then drop and check release.
  task automatic access(input bit sel0, input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
    int   n;
    logic rdy;
    n   = 0;
    rdy = 1'b0;
    drive(sel0, rd, wr, a, wd);
    while (!rdy && n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(sel0, rd, wr, ~a, ~wd);
      rdy = get_rdy(sel0);
    end
    // n counts negedges from request setup; ready shows WAIT_CYCLES+1 clocks after accept.
    chk({tag, " latency"}, 32'(n), sel0 ? 32'd2 : 32'd4);
    chk({tag, " rdata"}, get_rdata(sel0), exp_rd);
    chk({tag, " err"}, 32'(get_err(sel0)), 32'(exp_err));
    drive(sel0, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    chk({tag, " ready_drop"}, 32'(get_rdy(sel0)), 32'd0);
    chk({tag, " err_drop"}, 32'(get_err(sel0)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 10'h0, 32'h0);

    vecs.push_back('{1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 10'h010, 32'h00000000, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 10'h3FC, 32'h11111111, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 10'h3FC, 32'h00000000, 32'h11111111, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 10'h008, 32'hCAFEF00D, 32'h11111111, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 10'h020, 32'h0BADF00D, 32'h11111111, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 10'h020, 32'h00000000, 32'h0BADF00D, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 10'h008, 32'h00000000, 32'hCAFEF00D, 1'b0});
`ifdef MC_MEM_ALIGN_CHECK_EN
    vecs.push_back('{1'b0, 1'b1, 10'h011, 32'h55555555, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 10'h010, 32'h00000000, 32'hDEADBEEF, 1'b0});
`else
    vecs.push_back('{1'b1, 1'b0, 10'h012, 32'h00000000, 32'hDEADBEEF, 1'b0});
`endif

    // Reset for two clocks, then both instances idle with cleared outputs.
    repeat (2) @(negedge clk);
    chk("reset rdata2", rdata2, 32'h0);
    chk("reset ready2", 32'(rdy2), 32'd0);
    chk("reset err2", 32'(err2), 32'd0);
    chk("reset rdata0", rdata0, 32'h0);
    chk("reset ready0", 32'(rdy0), 32'd0);
    chk("reset err0", 32'(err0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Handshake hold: request held five cycles past ready.
    drive(1'b0, 1'b1, 1'b0, 10'h010, 32'h0);
    n = 0;
    while (!rdy2 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("hold latency", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold ready c%0d", i), 32'(rdy2), 32'd1);
      chk($sformatf("hold rdata c%0d", i), rdata2, 32'hDEADBEEF);
    end
    drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    chk("hold release", 32'(rdy2), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("hold no_restart", 32'(rdy2), 32'd0);
    end

    // Zero wait states; simultaneous read+write behaves as a write.
    access(1'b1, 1'b1, 1'b1, 10'h004, 32'h00001234, 32'h0, 1'b0, "w0 both");
    @(negedge clk);
    access(1'b1, 1'b1, 1'b0, 10'h004, 32'h0, 32'h00001234, 1'b0, "w0 read");
    @(negedge clk);

    // Reset while a write is still in BUSY: the write must be discarded.
    drive(1'b0, 1'b0, 1'b1, 10'h008, 32'h0000A5A5);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
    @(negedge clk);
    chk("midrst ready", 32'(rdy2), 32'd0);
    chk("midrst rdata", rdata2, 32'h0);
    chk("midrst err", 32'(err2), 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst idle", 32'(rdy2), 32'd0);
    end
    access(1'b0, 1'b1, 1'b0, 10'h008, 32'h0, 32'hCAFEF00D, 1'b0, "midrst readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
